// File: rtl/seq_detector_prog.sv
// seq_detector_prog: runtime-programmable serial pattern detector.
// Matches any 1..PAT_W bit pattern on a valid-qualified serial stream.
// Supports overlapping and non-overlapping detection, and has a registered Moore match flag.
// Optional saturating match counter, enabled by defining SEQDET_MATCH_CNT_EN.
// When the macro is undefined, match_cnt is tied to 0 and cnt_clr is ignored.
//
// state            | meaning
// hist             | last PAT_W accepted bits, newest in bit 0
// fill             | accepted bits since reset/config/non-overlap hit, saturates at PAT_W
// z                | registered hit from the most recent accepted sample
module seq_detector_prog #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8,
  parameter int LEN_W = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             x,
  input  logic             x_valid,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] pat,
  input  logic [LEN_W-1:0] pat_len,
  input  logic             overlap,
  input  logic             cnt_clr,
  output logic             z,
  output logic [CNT_W-1:0] match_cnt
);

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);

  logic [PAT_W-1:0] pat_r;
  logic [LEN_W-1:0] len_r;
  logic             ovl_r;
  logic [PAT_W-1:0] hist;
  logic [LEN_W-1:0] fill;

  logic [LEN_W-1:0] len_clamp;
  logic [LEN_W-1:0] fill_n;
  logic [PAT_W-1:0] hist_n;
  logic [PAT_W-1:0] mask;
  logic             hit;

  // Next-sample history, fill level and hit decision (only the low len_r bits are compared)
  always_comb begin
    len_clamp = (pat_len > LEN_MAX) ? LEN_MAX : pat_len;
    fill_n    = (fill == LEN_MAX) ? fill : fill + 1'b1;
    hist_n    = {hist[PAT_W-2:0], x};
    mask      = '0;
    for (int i = 0; i < PAT_W; i++) begin
      mask[i] = (i < int'(len_r));
    end
    hit = (len_r != '0) && (fill_n >= len_r) &&
          (((hist_n ^ pat_r) & mask) == '0);
  end

  // Config, history and match flag; reset beats cfg_load, which beats x_valid
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pat_r <= '0;
      len_r <= LEN_MAX;
      ovl_r <= 1'b1;
      hist  <= '0;
      fill  <= '0;
      z     <= 1'b0;
    end else if (cfg_load) begin
      pat_r <= pat;
      len_r <= len_clamp;
      ovl_r <= overlap;
      hist  <= '0;
      fill  <= '0;
      z     <= 1'b0;
    end else if (x_valid) begin
      hist <= hist_n;
      z    <= hit;
      fill <= (hit && !ovl_r) ? '0 : fill_n;
    end
  end

`ifdef SEQDET_MATCH_CNT_EN
  logic [CNT_W-1:0] cnt_q;
  logic             acc_hit;

  assign acc_hit   = x_valid && !cfg_load && hit;
  assign match_cnt = cnt_q;

  // Saturating match counter; a clear on the same edge as a hit leaves zero
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (cnt_clr) begin
      cnt_q <= '0;
    end else if (acc_hit && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
`else
  logic cnt_clr_unused;

  assign cnt_clr_unused = cnt_clr;
  assign match_cnt      = '0;
`endif

endmodule

// File: tb/tb_seq_detector_prog.sv
// Directed-vector bench for seq_detector_prog (PAT_W=8, CNT_W=2).
// The driver pushes the hand-computed z/match_cnt expected after each clock edge.
// A negedge monitor pops these expectations and compares them against the DUT outputs.
module tb_seq_detector_prog;

`ifdef SEQDET_MATCH_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n, x, x_valid, cfg_load, overlap, cnt_clr;
  logic [7:0] pat;
  logic [3:0] pat_len;
  logic       z;
  logic [1:0] match_cnt;

  typedef struct packed {
    int         idx;
    logic       z;
    logic [1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   step_no  = 0;

  seq_detector_prog #(.PAT_W(8), .CNT_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .x         (x),
    .x_valid   (x_valid),
    .cfg_load  (cfg_load),
    .pat       (pat),
    .pat_len   (pat_len),
    .overlap   (overlap),
    .cnt_clr   (cnt_clr),
    .z         (z),
    .match_cnt (match_cnt)
  );

  always #5 clk = ~clk;

  task automatic step(input logic r, input logic c, input logic [7:0] p,
                      input logic [3:0] l, input logic o, input logic v,
                      input logic xb, input logic cl, input logic ez,
                      input logic [1:0] ec);
    exp_t e;
    rst_n    = r;
    cfg_load = c;
    pat      = p;
    pat_len  = l;
    overlap  = o;
    x_valid  = v;
    x        = xb;
    cnt_clr  = cl;
    @(posedge clk);
    #1;
    e.idx = step_no;
    e.z   = ez;
    e.cnt = CNT_EN ? ec : 2'd0;
    exp_q.push_back(e);
    step_no++;
  endtask

  task automatic samp(input logic xb, input logic ez, input logic [1:0] ec);
    step(1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, xb, 1'b0, ez, ec);
  endtask

  task automatic idle(input logic xb, input logic cl, input logic ez, input logic [1:0] ec);
    step(1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, xb, cl, ez, ec);
  endtask

  task automatic cfg(input logic [7:0] p, input logic [3:0] l, input logic o,
                     input logic cl, input logic [1:0] ec);
    step(1'b1, 1'b1, p, l, o, 1'b0, 1'b0, cl, 1'b0, ec);
  endtask

  // Monitor: compare every pending expectation away from the active edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (z !== e.z) begin
          n_fail++;
          $display("FAIL z step %0d: got %b expected %b", e.idx, z, e.z);
        end
        n_checks++;
        if (match_cnt !== e.cnt) begin
          n_fail++;
          $display("FAIL match_cnt step %0d: got %0d expected %0d", e.idx, match_cnt, e.cnt);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset then non-overlapping 1010: single hit after bit 4
    step(1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    step(1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    cfg(8'h0A, 4'd4, 1'b0, 1'b0, 2'd0);
    samp(1, 0, 0); samp(0, 0, 0); samp(1, 0, 0); samp(0, 1, 1);
    samp(1, 0, 1); samp(0, 0, 1);
    idle(0, 1, 0, 0);

    // Overlapping 1010: hits after bits 4 and 6
    cfg(8'h0A, 4'd4, 1'b1, 1'b0, 2'd0);
    samp(1, 0, 0); samp(0, 0, 0); samp(1, 0, 0); samp(0, 1, 1);
    samp(1, 0, 1); samp(0, 1, 2);
    idle(0, 1, 1, 0);

    // Length 3 of all-ones, overlapping
    cfg(8'hFF, 4'd3, 1'b1, 1'b0, 2'd0);
    samp(1, 0, 0); samp(1, 0, 0); samp(1, 1, 1); samp(1, 1, 2);
    idle(0, 1, 1, 0);

    // pat_len 9 clamps to 8 and must behave exactly like 8
    for (int k = 0; k < 2; k++) begin
      cfg(8'hFF, (k == 0) ? 4'd9 : 4'd8, 1'b1, 1'b1, 2'd0);
      for (int b = 0; b < 7; b++) samp(1, 0, 0);
      samp(1, 1, 1);
      samp(1, 1, 2);
    end

    // pat_len 0 disables detection
    cfg(8'hFF, 4'd0, 1'b1, 1'b1, 2'd0);
    for (int b = 0; b < 10; b++) samp(1, 0, 0);

    // cfg_load restarts fill: all-zero pattern needs 4 fresh zeros
    cfg(8'h00, 4'd4, 1'b1, 1'b0, 2'd0);
    samp(0, 0, 0); samp(0, 0, 0); samp(0, 0, 0); samp(0, 1, 1);

    // Valid gating: gap bits ignored, z holds through idle cycles
    cfg(8'h0A, 4'd4, 1'b0, 1'b1, 2'd0);
    samp(1, 0, 0); samp(0, 0, 0);
    idle(1, 0, 0, 0); idle(0, 0, 0, 0); idle(1, 0, 0, 0);
    samp(1, 0, 0); samp(0, 1, 1);
    idle(1, 0, 1, 1); idle(0, 0, 1, 1); idle(1, 0, 1, 1);

    // cfg_load on the final pattern bit discards it and restarts
    cfg(8'h0A, 4'd4, 1'b1, 1'b1, 2'd0);
    samp(1, 0, 0); samp(0, 0, 0); samp(1, 0, 0);
    step(1'b1, 1'b1, 8'h0A, 4'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    samp(1, 0, 0); samp(0, 0, 0); samp(1, 0, 0); samp(0, 1, 1);

    // cnt_clr on the same edge as a hit leaves zero
    samp(1, 0, 1);
    step(1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'd0);

    // Reset mid-pattern: defaults pat=0, len=8, fill restarts from 0
    samp(1, 0, 0);
    step(1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    for (int b = 0; b < 7; b++) samp(0, 0, 0);
    samp(0, 1, 1);
    samp(0, 1, 2);

    // Saturation with CNT_W=2: five matches give 3; consecutive overlapping hits
    cfg(8'hFF, 4'd2, 1'b1, 1'b1, 2'd0);
    samp(1, 0, 0); samp(1, 1, 1); samp(1, 1, 2); samp(1, 1, 3);
    samp(1, 1, 3); samp(1, 1, 3);

    idle(0, 0, 1, 3);
    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
